// File: rtl/sample_delay_line.sv
// sample_delay_line: a DEPTH-stage, WIDTH-bit shift register holding the error history
// for the PID MAC stage. All taps are visible in parallel, tap 0 is the newest sample.
// A saturating fill count tells downstream when the history is complete. Every output
// comes straight from a flop.
module sample_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   freeze,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CW-1:0]          fill,
  output logic                   full,
  output logic                   out_valid,
  output logic                   dropped
);

  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  logic                   accept;
  logic                   drop;
  logic [CW-1:0]          fill_next;
  logic [WIDTH*DEPTH-1:0] taps_shift;

  // clr outranks freeze, which outranks a plain accept
  assign accept = in_valid & ~freeze & ~clr;
  assign drop   = in_valid &  freeze & ~clr;

  // Fill count saturates at DEPTH and never wraps
  always_comb begin
    fill_next = fill;
    if (accept && (fill != FILL_MAX)) fill_next = fill + CW'(1);
  end

  // With a single tap there is nothing to shift along, the register just reloads
  generate
    if (DEPTH == 1) begin : g_single
      assign taps_shift = in_data;
    end else begin : g_multi
      assign taps_shift = {taps[WIDTH*(DEPTH-1)-1:0], in_data};
    end
  endgenerate

  // Tap history: shift on accept, hold on freeze or idle, zero on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (accept) begin
      taps <= taps_shift;
    end
  end

  // Fill count and its registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      full <= 1'b0;
    end else if (clr) begin
      fill <= '0;
      full <= 1'b0;
    end else begin
      fill <= fill_next;
      full <= (fill_next == FILL_MAX);
    end
  end

  // Single-cycle status pulses; they never stretch past the edge that caused them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      out_valid <= accept & (fill_next == FILL_MAX);
      dropped   <= drop;
    end
  end

endmodule
